// File: rtl/slave_frame_receiver.sv
// Master-side receiver for one slave serial_data link: deserialises a start/flags/words/parity/stop
// frame, validates parity and stop bit, and watches for frames that never arrive after start_adc.
module slave_frame_receiver #(
   parameter int DATA_W      = 16,
   parameter int TIMEOUT_CYC = 256,
   parameter int CNT_W       = 16
) (
   input  logic              clk_i,
   input  logic              reset_ni,
   input  logic              serial_in_i,
   input  logic              expect_i,
   output logic              rx_valid_o,
   output logic [DATA_W-1:0] rx_word_a_o,
   output logic [DATA_W-1:0] rx_word_b_o,
   output logic              rx_err_a_o,
   output logic              rx_err_b_o,
   output logic              parity_err_o,
   output logic              frame_err_o,
   output logic              timeout_o,
   output logic              busy_o,
   output logic [CNT_W-1:0]  frame_cnt_o
);

   // Payload after the start bit: err_a, err_b, word_a, word_b, parity.
   localparam int FRAME_W = 2*DATA_W + 3;
   localparam int BCNT_W  = $clog2(FRAME_W + 1);
   localparam int TMO_W   = $clog2(TIMEOUT_CYC);
   localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(FRAME_W - 1);
   localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ARMED  = 3'd1,
      S_SHIFT  = 3'd2,
      S_STOP   = 3'd3,
      S_RESYNC = 3'd4
   } state_e;

   function automatic logic even_parity_ok(input logic [FRAME_W-1:0] bits);
      return ~(^bits);
   endfunction

   state_e              state_q, state_d;
   logic                line_q;
   logic [BCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
   logic [FRAME_W-1:0]  sr_q, sr_d;
   logic                valid_q, valid_d;
   logic                perr_q, perr_d;
   logic                ferr_q, ferr_d;
   logic                tmo_q, tmo_d;
   logic                busy_q, busy_d;
   logic [DATA_W-1:0]   word_a_q, word_a_d;
   logic [DATA_W-1:0]   word_b_q, word_b_d;
   logic                err_a_q, err_a_d;
   logic                err_b_q, err_b_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         state_q   <= S_IDLE;
         line_q    <= 1'b1;
         bit_cnt_q <= '0;
         tmo_cnt_q <= '0;
         sr_q      <= '0;
         valid_q   <= 1'b0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
         tmo_q     <= 1'b0;
         busy_q    <= 1'b0;
         word_a_q  <= '0;
         word_b_q  <= '0;
         err_a_q   <= 1'b0;
         err_b_q   <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         line_q    <= serial_in_i;
         bit_cnt_q <= bit_cnt_d;
         tmo_cnt_q <= tmo_cnt_d;
         sr_q      <= sr_d;
         valid_q   <= valid_d;
         perr_q    <= perr_d;
         ferr_q    <= ferr_d;
         tmo_q     <= tmo_d;
         busy_q    <= busy_d;
         word_a_q  <= word_a_d;
         word_b_q  <= word_b_d;
         err_a_q   <= err_a_d;
         err_b_q   <= err_b_d;
         cnt_q     <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      tmo_cnt_d = tmo_cnt_q;
      sr_d      = sr_q;
      valid_d   = 1'b0;
      perr_d    = 1'b0;
      ferr_d    = 1'b0;
      tmo_d     = 1'b0;
      word_a_d  = word_a_q;
      word_b_d  = word_b_q;
      err_a_d   = err_a_q;
      err_b_d   = err_b_q;
      cnt_d     = cnt_q;

      case (state_q)
         S_IDLE: begin
            if (!line_q) begin
               state_d   = S_SHIFT;
               bit_cnt_d = '0;
            end else if (expect_i) begin
               state_d   = S_ARMED;
               tmo_cnt_d = '0;
            end else begin
               state_d   = S_IDLE;
            end
         end
         // A start bit takes priority over the watchdog expiring in the same cycle.
         S_ARMED: begin
            if (!line_q) begin
               state_d   = S_SHIFT;
               bit_cnt_d = '0;
            end else if (expect_i) begin
               tmo_cnt_d = '0;
            end else if (tmo_cnt_q == TMO_LAST) begin
               tmo_d     = 1'b1;
               state_d   = S_IDLE;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end
         end
         S_SHIFT: begin
            sr_d      = {sr_q[FRAME_W-2:0], line_q};
            bit_cnt_d = bit_cnt_q + BCNT_W'(1);
            if (bit_cnt_q == LAST_BIT) begin
               state_d = S_STOP;
            end else begin
               state_d = S_SHIFT;
            end
         end
         S_STOP: begin
            if (!line_q) begin
               ferr_d  = 1'b1;
               state_d = S_RESYNC;
            end else if (even_parity_ok(sr_q)) begin
               err_a_d  = sr_q[FRAME_W-1];
               err_b_d  = sr_q[FRAME_W-2];
               word_a_d = sr_q[2*DATA_W:DATA_W+1];
               word_b_d = sr_q[DATA_W:1];
               valid_d  = 1'b1;
               cnt_d    = cnt_q + CNT_W'(1);
               state_d  = S_IDLE;
            end else begin
               perr_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         // Holding here until the line returns high stops a stuck-low line retriggering frames.
         S_RESYNC: begin
            if (line_q) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_RESYNC;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d == S_SHIFT) || (state_d == S_STOP) || (state_d == S_RESYNC);
   end

   assign rx_valid_o   = valid_q;
   assign rx_word_a_o  = word_a_q;
   assign rx_word_b_o  = word_b_q;
   assign rx_err_a_o   = err_a_q;
   assign rx_err_b_o   = err_b_q;
   assign parity_err_o = perr_q;
   assign frame_err_o  = ferr_q;
   assign timeout_o    = tmo_q;
   assign busy_o       = busy_q;
   assign frame_cnt_o  = cnt_q;

endmodule

// File: tb/tb_slave_frame_receiver.sv
// Directed bench for slave_frame_receiver: cycle-exact latency, error paths, watchdog and wrap.
module tb_slave_frame_receiver;

   logic        clk_s = 1'b0;
   logic        reset_n_s;
   logic        serial_s;
   logic        expect_s;
   logic        rx_valid_s, rx_err_a_s, rx_err_b_s, perr_s, ferr_s, tmo_s, busy_s;
   logic [15:0] rx_word_a_s, rx_word_b_s, frame_cnt_s;
   logic        v2_s, ea2_s, eb2_s, perr2_s, ferr2_s, tmo2_s, busy2_s;
   logic [15:0] wa2_s, wb2_s;
   logic [1:0]  cnt2_s;

   slave_frame_receiver #(.DATA_W(16), .TIMEOUT_CYC(256), .CNT_W(16)) dut (
      .clk_i(clk_s), .reset_ni(reset_n_s), .serial_in_i(serial_s), .expect_i(expect_s),
      .rx_valid_o(rx_valid_s), .rx_word_a_o(rx_word_a_s), .rx_word_b_o(rx_word_b_s),
      .rx_err_a_o(rx_err_a_s), .rx_err_b_o(rx_err_b_s), .parity_err_o(perr_s),
      .frame_err_o(ferr_s), .timeout_o(tmo_s), .busy_o(busy_s), .frame_cnt_o(frame_cnt_s));

   // Narrow-counter instance sharing the same line, used to observe frame_cnt wrap cheaply.
   slave_frame_receiver #(.DATA_W(16), .TIMEOUT_CYC(256), .CNT_W(2)) dut_wrap (
      .clk_i(clk_s), .reset_ni(reset_n_s), .serial_in_i(serial_s), .expect_i(expect_s),
      .rx_valid_o(v2_s), .rx_word_a_o(wa2_s), .rx_word_b_o(wb2_s),
      .rx_err_a_o(ea2_s), .rx_err_b_o(eb2_s), .parity_err_o(perr2_s),
      .frame_err_o(ferr2_s), .timeout_o(tmo2_s), .busy_o(busy2_s), .frame_cnt_o(cnt2_s));

   always #5 clk_s = ~clk_s;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   int n_valid = 0, n_perr = 0, n_ferr = 0, n_tmo = 0;
   int last_valid = -1, last_perr = -1, last_ferr = -1, last_tmo = -1;
   int n_overlap = 0, n_long = 0;
   logic pv = 1'b0, pp = 1'b0, pf = 1'b0, pt = 1'b0;
   logic [33:0] cap_q[$];
   int          cap_cyc_q[$];

   // Cycle counter: after active edge N the bench sees cyc == N.
   always @(posedge clk_s) cyc <= cyc + 1;

   // Pulse monitor sampled on the falling edge.
   always @(negedge clk_s) begin
      if (rx_valid_s) begin
         n_valid    <= n_valid + 1;
         last_valid <= cyc;
         cap_q.push_back({rx_err_a_s, rx_err_b_s, rx_word_a_s, rx_word_b_s});
         cap_cyc_q.push_back(cyc);
      end
      if (perr_s) begin n_perr <= n_perr + 1; last_perr <= cyc; end
      if (ferr_s) begin n_ferr <= n_ferr + 1; last_ferr <= cyc; end
      if (tmo_s)  begin n_tmo  <= n_tmo + 1;  last_tmo  <= cyc; end
      if ((int'(rx_valid_s) + int'(perr_s) + int'(ferr_s) + int'(tmo_s)) > 1) n_overlap <= n_overlap + 1;
      if ((rx_valid_s && pv) || (perr_s && pp) || (ferr_s && pf) || (tmo_s && pt)) n_long <= n_long + 1;
      pv <= rx_valid_s; pp <= perr_s; pf <= ferr_s; pt <= tmo_s;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk_s);
      #1;
   endtask

   function automatic logic [36:0] mk(input logic ea, input logic eb, input logic [15:0] a,
                                      input logic [15:0] b, input logic par, input logic stop);
      return {1'b0, ea, eb, a, b, par, stop};
   endfunction

   task automatic drive_frame(input logic [36:0] f);
      for (int i = 36; i >= 0; i--) begin
         serial_s = f[i];
         tick(1);
      end
   endtask

   task automatic test_reset();
      reset_n_s = 1'b0; serial_s = 1'b1; expect_s = 1'b0;
      tick(3);
      n_cmp++; if ({rx_valid_s, perr_s, ferr_s, tmo_s, busy_s} !== 5'b00000) begin
         n_fail++; $display("FAIL reset_pulses: got %b expected 00000", {rx_valid_s, perr_s, ferr_s, tmo_s, busy_s}); end
      n_cmp++; if ({rx_word_a_s, rx_word_b_s, rx_err_a_s, rx_err_b_s} !== 34'h0) begin
         n_fail++; $display("FAIL reset_data: got %h expected 0", {rx_word_a_s, rx_word_b_s, rx_err_a_s, rx_err_b_s}); end
      n_cmp++; if (frame_cnt_s !== 16'h0000) begin
         n_fail++; $display("FAIL reset_cnt: got %h expected 0000", frame_cnt_s); end
      reset_n_s = 1'b1;
      tick(2);
   endtask

   task automatic test_good_frame();
      int c0, nv;
      nv = n_valid; c0 = cyc;
      drive_frame(mk(1'b0, 1'b0, 16'h1234, 16'hABCD, 1'b1, 1'b1));
      tick(4);
      n_cmp++; if (n_valid !== nv + 1) begin
         n_fail++; $display("FAIL good_valid_count: got %0d expected %0d", n_valid - nv, 1); end
      n_cmp++; if (last_valid !== c0 + 38) begin
         n_fail++; $display("FAIL good_latency: got %0d expected %0d", last_valid - c0, 38); end
      n_cmp++; if ({rx_word_a_s, rx_word_b_s} !== 32'h1234ABCD) begin
         n_fail++; $display("FAIL good_words: got %h expected 1234abcd", {rx_word_a_s, rx_word_b_s}); end
      n_cmp++; if ({rx_err_a_s, rx_err_b_s} !== 2'b00) begin
         n_fail++; $display("FAIL good_flags: got %b expected 00", {rx_err_a_s, rx_err_b_s}); end
      n_cmp++; if (frame_cnt_s !== 16'd1) begin
         n_fail++; $display("FAIL good_cnt: got %0d expected 1", frame_cnt_s); end
   endtask

   task automatic test_parity();
      int c0, nv, np;
      nv = n_valid; np = n_perr; c0 = cyc;
      drive_frame(mk(1'b0, 1'b0, 16'h00FF, 16'h0000, 1'b1, 1'b1));
      tick(4);
      n_cmp++; if (n_perr !== np + 1 || last_perr !== c0 + 38) begin
         n_fail++; $display("FAIL parity_pulse: got count %0d at %0d expected 1 at 38", n_perr - np, last_perr - c0); end
      n_cmp++; if (n_valid !== nv) begin
         n_fail++; $display("FAIL parity_no_valid: got %0d expected 0", n_valid - nv); end
      n_cmp++; if ({rx_word_a_s, rx_word_b_s, frame_cnt_s} !== 48'h1234ABCD0001) begin
         n_fail++; $display("FAIL parity_hold: got %h expected 1234abcd0001", {rx_word_a_s, rx_word_b_s, frame_cnt_s}); end
   endtask

   task automatic test_frame_err();
      int c0, nv, np, nf;
      nv = n_valid; np = n_perr; nf = n_ferr; c0 = cyc;
      drive_frame(mk(1'b0, 1'b0, 16'h1111, 16'h2222, 1'b0, 1'b0));
      serial_s = 1'b0;
      tick(10);
      serial_s = 1'b1;
      tick(3);
      n_cmp++; if (n_ferr !== nf + 1 || last_ferr !== c0 + 38) begin
         n_fail++; $display("FAIL ferr_pulse: got count %0d at %0d expected 1 at 38", n_ferr - nf, last_ferr - c0); end
      n_cmp++; if (n_valid !== nv || n_perr !== np) begin
         n_fail++; $display("FAIL ferr_spurious: got valid %0d perr %0d expected 0 0", n_valid - nv, n_perr - np); end
      n_cmp++; if (busy_s !== 1'b0) begin
         n_fail++; $display("FAIL ferr_resync_exit: got busy %b expected 0", busy_s); end
      c0 = cyc;
      drive_frame(mk(1'b0, 1'b0, 16'h5555, 16'h0000, 1'b0, 1'b1));
      tick(4);
      n_cmp++; if (last_valid !== c0 + 38 || rx_word_a_s !== 16'h5555 || frame_cnt_s !== 16'd2) begin
         n_fail++; $display("FAIL ferr_recover: got at %0d word %h cnt %0d expected 38 5555 2", last_valid - c0, rx_word_a_s, frame_cnt_s); end
   endtask

   task automatic test_timeout();
      int c0, nt, nv;
      nt = n_tmo; c0 = cyc;
      expect_s = 1'b1; tick(1); expect_s = 1'b0;
      tick(270);
      n_cmp++; if (n_tmo !== nt + 1 || last_tmo !== c0 + 257) begin
         n_fail++; $display("FAIL timeout_fire: got count %0d at %0d expected 1 at 257", n_tmo - nt, last_tmo - c0); end
      nt = n_tmo; nv = n_valid; c0 = cyc;
      expect_s = 1'b1; tick(1); expect_s = 1'b0;
      tick(254);
      drive_frame(mk(1'b0, 1'b0, 16'h1234, 16'hABCD, 1'b1, 1'b1));
      tick(20);
      n_cmp++; if (n_tmo !== nt) begin
         n_fail++; $display("FAIL timeout_start_wins: got %0d timeouts expected 0", n_tmo - nt); end
      n_cmp++; if (n_valid !== nv + 1 || last_valid !== c0 + 255 + 38 || frame_cnt_s !== 16'd3) begin
         n_fail++; $display("FAIL timeout_frame: got count %0d at %0d cnt %0d expected 1 at 293 cnt 3", n_valid - nv, last_valid - c0, frame_cnt_s); end
   endtask

   task automatic test_back_to_back();
      int c0, nv;
      cap_q.delete(); cap_cyc_q.delete();
      c0 = cyc;
      drive_frame(mk(1'b1, 1'b0, 16'h0001, 16'h8000, 1'b1, 1'b1));
      drive_frame(mk(1'b0, 1'b1, 16'h00FF, 16'h0F00, 1'b1, 1'b1));
      tick(4);
      n_cmp++; if (cap_q.size() !== 2) begin
         n_fail++; $display("FAIL b2b_count: got %0d expected 2", cap_q.size()); end
      else begin
         n_cmp++; if (cap_cyc_q[0] !== c0 + 38 || cap_cyc_q[1] !== c0 + 75) begin
            n_fail++; $display("FAIL b2b_timing: got %0d,%0d expected 38,75", cap_cyc_q[0] - c0, cap_cyc_q[1] - c0); end
         n_cmp++; if (cap_q[0] !== {2'b10, 16'h0001, 16'h8000}) begin
            n_fail++; $display("FAIL b2b_frame1: got %h expected %h", cap_q[0], {2'b10, 16'h0001, 16'h8000}); end
         n_cmp++; if (cap_q[1] !== {2'b01, 16'h00FF, 16'h0F00}) begin
            n_fail++; $display("FAIL b2b_frame2: got %h expected %h", cap_q[1], {2'b01, 16'h00FF, 16'h0F00}); end
      end
      n_cmp++; if (frame_cnt_s !== 16'd5) begin
         n_fail++; $display("FAIL b2b_cnt: got %0d expected 5", frame_cnt_s); end
      // Third frame interrupted by reset after ten bits.
      begin
         logic [36:0] f;
         f = mk(1'b0, 1'b0, 16'h1234, 16'hABCD, 1'b1, 1'b1);
         for (int i = 36; i >= 27; i--) begin
            serial_s = f[i];
            tick(1);
         end
      end
      n_cmp++; if (busy_s !== 1'b1) begin
         n_fail++; $display("FAIL b2b_busy_mid: got %b expected 1", busy_s); end
      nv = n_valid;
      reset_n_s = 1'b0; serial_s = 1'b1;
      tick(2);
      n_cmp++; if ({rx_valid_s, perr_s, ferr_s, tmo_s, busy_s, rx_err_a_s, rx_err_b_s} !== 7'b0) begin
         n_fail++; $display("FAIL b2b_reset_bits: got %b expected 0000000", {rx_valid_s, perr_s, ferr_s, tmo_s, busy_s, rx_err_a_s, rx_err_b_s}); end
      n_cmp++; if ({rx_word_a_s, rx_word_b_s, frame_cnt_s} !== 48'h0) begin
         n_fail++; $display("FAIL b2b_reset_data: got %h expected 0", {rx_word_a_s, rx_word_b_s, frame_cnt_s}); end
      reset_n_s = 1'b1;
      tick(40);
      n_cmp++; if (n_valid !== nv || busy_s !== 1'b0) begin
         n_fail++; $display("FAIL b2b_abort: got %0d frames busy %b expected 0 0", n_valid - nv, busy_s); end
   endtask

   task automatic test_wrap();
      int c0;
      for (int k = 1; k <= 4; k++) begin
         c0 = cyc;
         drive_frame(mk(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1));
         tick(4);
         n_cmp++; if (cnt2_s !== 2'(k % 4) || last_valid !== c0 + 38) begin
            n_fail++; $display("FAIL wrap_cnt%0d: got %0d at %0d expected %0d at 38", k, cnt2_s, last_valid - c0, k % 4); end
      end
      n_cmp++; if (frame_cnt_s !== 16'd4) begin
         n_fail++; $display("FAIL wrap_wide_cnt: got %0d expected 4", frame_cnt_s); end
   endtask

   task automatic test_pulse_rules();
      n_cmp++; if (n_overlap !== 0) begin
         n_fail++; $display("FAIL pulse_exclusive: got %0d overlaps expected 0", n_overlap); end
      n_cmp++; if (n_long !== 0) begin
         n_fail++; $display("FAIL pulse_width: got %0d long pulses expected 0", n_long); end
   endtask

   initial begin
      reset_n_s = 1'b0; serial_s = 1'b1; expect_s = 1'b0;
      test_reset();
      test_good_frame();
      test_parity();
      test_frame_err();
      test_timeout();
      test_back_to_back();
      test_wrap();
      test_pulse_rules();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
